// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller behind the processor's Memory1/Memory2 stages.
// Each request is held off for WAIT_STATES cycles (DataDone low), then completes in DONE.
// Stores commit to RAM at the accept edge. Loads are read at the DONE-entry edge.
// Optional feature macro: DATA_MEM_MMIO_EN adds the IoOut register and the IoIn port.
module data_mem_ctrl #(
    parameter int                    WORD_SIZE   = 16,
    parameter int                    DEPTH       = 256,
    parameter int                    WAIT_STATES = 2,
    parameter logic [WORD_SIZE-1:0]  IO_OUT_ADDR = 16'h1000,
    parameter logic [WORD_SIZE-1:0]  IO_IN_ADDR  = 16'h3000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [WORD_SIZE-1:0] i_data_addr,
    input  logic [WORD_SIZE-1:0] i_data_out,
    input  logic                 i_read_data,
    input  logic                 i_write_data,
`ifdef DATA_MEM_MMIO_EN
    input  logic [WORD_SIZE-1:0] i_io_in,
    output logic [WORD_SIZE-1:0] o_io_out,
`endif
    output logic [WORD_SIZE-1:0] o_data_in,
    output logic                 o_data_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [WORD_SIZE-1:0]   r_addr;
    logic                   r_is_read;
    logic [WORD_SIZE-1:0]   r_data_in;
    logic                   r_data_done;
    logic [WORD_SIZE-1:0]   r_ram [DEPTH];
`ifdef DATA_MEM_MMIO_EN
    logic [WORD_SIZE-1:0]   r_io_out;
`endif

    logic                   w_req, w_accept, w_done_entry;
    logic [WORD_SIZE-1:0]   w_rd_addr, w_rd_word;
    logic                   w_rd_en, w_ram_we;

    // RAM window: below DEPTH and not one of the I/O addresses. The I/O
    // addresses are excluded even without MMIO so they read 0 and drop writes.
    function automatic logic f_is_ram(input logic [WORD_SIZE-1:0] a);
        return ({1'b0, a} < DEPTH_W) && (a != IO_OUT_ADDR) && (a != IO_IN_ADDR);
    endfunction

    assign w_req = i_read_data | i_write_data;

    // Next-state and wait-state counter; requests are only looked at in IDLE/DONE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CW'(WAIT_STATES);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // With zero wait states the accept edge is also the DONE-entry edge, so the
    // read is taken from the live request rather than the latched one.
    assign w_done_entry = (w_state_nxt == S_DONE) && ((r_state == S_BUSY) || w_accept);
    assign w_rd_addr    = (WAIT_STATES == 0) ? i_data_addr : r_addr;
    assign w_rd_en      = (WAIT_STATES == 0) ? (i_read_data & ~i_write_data) : r_is_read;
    assign w_ram_we     = w_accept & i_write_data & ~i_reset & f_is_ram(i_data_addr);

    // Load data source: RAM word, I/O register/port, or 0 for unmapped addresses
    always_comb begin
        w_rd_word = '0;
        if (f_is_ram(w_rd_addr)) begin
            w_rd_word = r_ram[w_rd_addr[AW-1:0]];
        end
`ifdef DATA_MEM_MMIO_EN
        else if (w_rd_addr == IO_OUT_ADDR) begin
            w_rd_word = r_io_out;
        end else if (w_rd_addr == IO_IN_ADDR) begin
            w_rd_word = i_io_in;
        end
`endif
    end

    // RAM store port; not touched by reset so contents survive it
    always_ff @(posedge i_clock) begin
        if (w_ram_we) begin
            r_ram[i_data_addr[AW-1:0]] <= i_data_out;
        end
    end

    // Control state, latched request and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_data_in   <= '0;
            r_data_done <= 1'b1;
`ifdef DATA_MEM_MMIO_EN
            r_io_out    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data_done <= (w_state_nxt != S_BUSY);
            if (w_accept) begin
                r_addr    <= i_data_addr;
                r_is_read <= i_read_data & ~i_write_data;
            end
            if (w_done_entry && w_rd_en) begin
                r_data_in <= w_rd_word;
            end
`ifdef DATA_MEM_MMIO_EN
            if (w_accept && i_write_data && (i_data_addr == IO_OUT_ADDR)) begin
                r_io_out <= i_data_out;
            end
`endif
        end
    end

    assign o_data_in   = r_data_in;
    assign o_data_done = r_data_done;
`ifdef DATA_MEM_MMIO_EN
    assign o_io_out    = r_io_out;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with 2 wait states, one with 0.
module tb_data_mem_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] a2, d2, q2, a0, d0, q0;
    logic         rd2, wr2, done2, rd0, wr0, done0;
`ifdef DATA_MEM_MMIO_EN
    logic [W-1:0] ioin2, ioout2, ioin0, ioout0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_ctrl #(.WORD_SIZE(W), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .i_clock(clk), .i_reset(rst), .i_data_addr(a2), .i_data_out(d2),
        .i_read_data(rd2), .i_write_data(wr2),
`ifdef DATA_MEM_MMIO_EN
        .i_io_in(ioin2), .o_io_out(ioout2),
`endif
        .o_data_in(q2), .o_data_done(done2));

    data_mem_ctrl #(.WORD_SIZE(W), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_data_addr(a0), .i_data_out(d0),
        .i_read_data(rd0), .i_write_data(wr0),
`ifdef DATA_MEM_MMIO_EN
        .i_io_in(ioin0), .o_io_out(ioout0),
`endif
        .o_data_in(q0), .o_data_done(done0));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        rd2 = r; wr2 = w; a2 = a; d2 = d;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        rd0 = r; wr0 = w; a0 = a; d0 = d;
    endtask

    // One full access on the 2-wait-state instance; request held for all three
    // edges like the stalled processor does. Returns DataDone after each edge.
    task automatic run2(input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d,
                        output logic [2:0] dseq);
        drive2(r, w, a, d);
        for (int k = 0; k < 3; k++) begin
            tick;
            dseq[k] = done2;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive2(1'b0, 1'b0, '0, '0);
        drive0(1'b0, 1'b0, '0, '0);
`ifdef DATA_MEM_MMIO_EN
        ioin2 = '0; ioin0 = '0;
`endif
        tick; tick;
        rst = 1'b0;
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL reset_done2 got %b want 1", done2); end
        n_checks++; if (q2 !== 16'h0000) begin n_fail++; $display("FAIL reset_q2 got %h want 0000", q2); end
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL reset_done0 got %b want 1", done0); end
        n_checks++; if (q0 !== 16'h0000) begin n_fail++; $display("FAIL reset_q0 got %h want 0000", q0); end
`ifdef DATA_MEM_MMIO_EN
        n_checks++; if (ioout2 !== 16'h0000) begin n_fail++; $display("FAIL reset_ioout got %h want 0000", ioout2); end
`endif
        for (int k = 0; k < 5; k++) begin
            tick;
            n_checks++; if (done2 !== 1'b1 || done0 !== 1'b1) begin
                n_fail++; $display("FAIL idle_done cycle %0d got %b/%b want 1/1", k, done2, done0);
            end
        end
    endtask

    task automatic test_ws2_rw;
        logic [2:0] ds;
        run2(1'b0, 1'b1, 16'd5, 16'h1234, ds);
        n_checks++; if (ds !== 3'b100) begin n_fail++; $display("FAIL ws2_store_done got %b want 100", ds); end
        // issued in the completion cycle, so it is accepted straight from DONE
        run2(1'b1, 1'b0, 16'd5, 16'h0000, ds);
        n_checks++; if (ds !== 3'b100) begin n_fail++; $display("FAIL ws2_load_done got %b want 100", ds); end
        n_checks++; if (q2 !== 16'h1234) begin n_fail++; $display("FAIL ws2_load_data got %h want 1234", q2); end
        drive2(1'b0, 1'b0, '0, '0);
        tick;
        n_checks++; if (done2 !== 1'b1 || q2 !== 16'h1234) begin
            n_fail++; $display("FAIL ws2_idle_hold got %b/%h want 1/1234", done2, q2);
        end
    endtask

    task automatic test_out_of_range;
        logic [2:0] ds;
        run2(1'b0, 1'b1, 16'h0000, 16'h0F0F, ds);
        run2(1'b1, 1'b0, 16'h0200, 16'h0000, ds);
        n_checks++; if (ds !== 3'b100) begin n_fail++; $display("FAIL oor_load_done got %b want 100", ds); end
        n_checks++; if (q2 !== 16'h0000) begin n_fail++; $display("FAIL oor_load_0200 got %h want 0000", q2); end
        run2(1'b0, 1'b1, 16'h0200, 16'hBEEF, ds);
        n_checks++; if (ds !== 3'b100) begin n_fail++; $display("FAIL oor_store_done got %b want 100", ds); end
        run2(1'b0, 1'b1, 16'h0100, 16'hDEAD, ds);
        run2(1'b1, 1'b0, 16'h0000, 16'h0000, ds);
        n_checks++; if (q2 !== 16'h0F0F) begin n_fail++; $display("FAIL oor_ram0_kept got %h want 0f0f", q2); end
        run2(1'b1, 1'b0, 16'h0200, 16'h0000, ds);
        n_checks++; if (q2 !== 16'h0000) begin n_fail++; $display("FAIL oor_reload_0200 got %h want 0000", q2); end
        run2(1'b0, 1'b1, 16'h00FF, 16'hCAFE, ds);
        run2(1'b1, 1'b0, 16'h00FF, 16'h0000, ds);
        n_checks++; if (q2 !== 16'hCAFE) begin n_fail++; $display("FAIL top_word got %h want cafe", q2); end
        run2(1'b1, 1'b0, 16'h0100, 16'h0000, ds);
        n_checks++; if (q2 !== 16'h0000) begin n_fail++; $display("FAIL depth_addr got %h want 0000", q2); end
        drive2(1'b0, 1'b0, '0, '0);
        tick;
    endtask

    task automatic test_reset_mid;
        logic [2:0] ds;
        // store commits at accept; reset during its BUSY must not undo it
        drive2(1'b0, 1'b1, 16'd7, 16'h7007);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL rst_wr_done got %b want 1", done2); end
        run2(1'b1, 1'b0, 16'd7, 16'h0000, ds);
        n_checks++; if (ds !== 3'b100 || q2 !== 16'h7007) begin
            n_fail++; $display("FAIL rst_wr_kept got %b/%h want 100/7007", ds, q2);
        end
        run2(1'b1, 1'b0, 16'h0100, 16'h0000, ds);
        drive2(1'b0, 1'b0, '0, '0);
        tick;
        drive2(1'b1, 1'b0, 16'h00FF, 16'h0000);
        tick;
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy1 got %b want 0", done2); end
        tick;
        n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy2 got %b want 0", done2); end
        rst = 1'b1;
        tick;
        n_checks++; if (done2 !== 1'b1 || q2 !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid got %b/%h want 1/0000", done2, q2);
        end
        rst = 1'b0;
        drive2(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++; if (done2 !== 1'b1 || q2 !== 16'h0000) begin
                n_fail++; $display("FAIL rst_cancel cycle %0d got %b/%h want 1/0000", k, done2, q2);
            end
        end
    endtask

    task automatic test_back_to_back;
        drive0(1'b0, 1'b1, 16'd1, 16'hAAAA); tick;
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL ws0_store_done got %b want 1", done0); end
        drive0(1'b0, 1'b1, 16'd2, 16'h5555); tick;
        drive0(1'b1, 1'b0, 16'd1, 16'h0000); tick;
        n_checks++; if (done0 !== 1'b1 || q0 !== 16'hAAAA) begin
            n_fail++; $display("FAIL ws0_load1 got %b/%h want 1/aaaa", done0, q0);
        end
        drive0(1'b1, 1'b0, 16'd2, 16'h0000); tick;
        n_checks++; if (done0 !== 1'b1 || q0 !== 16'h5555) begin
            n_fail++; $display("FAIL ws0_load2 got %b/%h want 1/5555", done0, q0);
        end
        drive0(1'b0, 1'b1, 16'd3, 16'h7777); tick;
        drive0(1'b1, 1'b0, 16'd3, 16'h0000); tick;
        n_checks++; if (q0 !== 16'h7777) begin n_fail++; $display("FAIL ws0_raw got %h want 7777", q0); end
        drive0(1'b1, 1'b1, 16'd4, 16'h4444); tick;
        n_checks++; if (q0 !== 16'h7777) begin n_fail++; $display("FAIL ws0_rdwr_noread got %h want 7777", q0); end
        drive0(1'b1, 1'b0, 16'd4, 16'h0000); tick;
        n_checks++; if (q0 !== 16'h4444) begin n_fail++; $display("FAIL ws0_rdwr_write got %h want 4444", q0); end
        drive0(1'b0, 1'b0, '0, '0); tick;
        n_checks++; if (done0 !== 1'b1 || q0 !== 16'h4444) begin
            n_fail++; $display("FAIL ws0_idle got %b/%h want 1/4444", done0, q0);
        end
    endtask

    task automatic test_mmio;
        logic [2:0] ds;
`ifdef DATA_MEM_MMIO_EN
        run2(1'b0, 1'b1, 16'h1000, 16'h00FF, ds);
        n_checks++; if (ds !== 3'b100 || ioout2 !== 16'h00FF) begin
            n_fail++; $display("FAIL mmio_out got %b/%h want 100/00ff", ds, ioout2);
        end
        run2(1'b1, 1'b0, 16'h1000, 16'h0000, ds);
        n_checks++; if (q2 !== 16'h00FF) begin n_fail++; $display("FAIL mmio_out_rd got %h want 00ff", q2); end
        ioin2 = 16'h0123;
        run2(1'b1, 1'b0, 16'h3000, 16'h0000, ds);
        n_checks++; if (ds !== 3'b100 || q2 !== 16'h0123) begin
            n_fail++; $display("FAIL mmio_in got %b/%h want 100/0123", ds, q2);
        end
`else
        run2(1'b1, 1'b0, 16'd5, 16'h0000, ds);
        run2(1'b1, 1'b0, 16'h3000, 16'h0000, ds);
        n_checks++; if (ds !== 3'b100 || q2 !== 16'h0000) begin
            n_fail++; $display("FAIL nommio_in got %b/%h want 100/0000", ds, q2);
        end
        run2(1'b0, 1'b1, 16'h1000, 16'h00FF, ds);
        run2(1'b1, 1'b0, 16'd5, 16'h0000, ds);
        run2(1'b1, 1'b0, 16'h1000, 16'h0000, ds);
        n_checks++; if (q2 !== 16'h0000) begin n_fail++; $display("FAIL nommio_out got %h want 0000", q2); end
`endif
        drive2(1'b0, 1'b0, '0, '0);
        tick;
    endtask

    initial begin
        test_reset;
        test_ws2_rw;
        test_out_of_range;
        test_reset_mid;
        test_back_to_back;
        test_mmio;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
